dcache_writeback_buffer: RTL and testbench

- Posted write-back buffer between the dcache subsystem's dirty-line write outputs (`mem_write_valid/addr/data`) and the memory arbiter's write port.
- Absorbs dirty victim-cache evictions into a FIFO and drains them to memory under a watermark/timeout policy.
- Forwards buffered line data to dcache reads so a load never sees stale memory while its line is still in flight.

---
 rtl/dcache_writeback_buffer.sv | 222 ++++++++++++++++++++++
 tb/tb_dcache_writeback_buffer.sv | 524 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_writeback_buffer.sv
// dcache_writeback_buffer
//
// Posted write-back buffer between the dcache dirty-line outputs and the
// memory arbiter write port. Evicted dirty lines go into a circular FIFO and
// drain to memory when occupancy reaches HIGH_WM, when the pipeline raises
// force_drain, or after a non-empty buffer has sat idle for IDLE_TIMEOUT
// cycles. Buffered lines (and the line being offered this cycle) are forwarded
// to dcache reads, so a load never sees stale memory.
//
// Address packet layout (I_ADDR_PACKET / D_ADDR_PACKET), MSB first:
//   {valid, zeros[ZEROS_W], tag[TAG_W], block_offset[OFFSET_W]}
// Forward packet layout (CACHE_DATA): {valid, data[DATA_W]}
//
// Ports:
//   clock            sole clock, posedge
//   reset            synchronous, active-low
//   in_valid         dirty line offered this cycle
//   in_addr          line address (block_offset and valid field ignored)
//   in_data          line data
//   read_addrs[1:0]  dcache read snoop addresses, [0] is older
//   fwd_outs[1:0]    forwarded {hit, data} per read port
//   force_drain      drain request from pipeline (fence/halt)
//   wb_req_addr      head address to arbiter; valid field is the request
//   wb_req_data      head data
//   wb_req_accepted  arbiter took the head this cycle
//   count            occupancy
//   full / empty     count == DEPTH / count == 0
//   overflow         sticky: a line was dropped
//
// Configuration macro: DCACHE_WB_COALESCE_EN
//   Defined: a push whose tag matches a buffered entry overwrites that entry's
//   data in place instead of allocating (unless that entry is the head being
//   popped in the same cycle).
//   Undefined: every push allocates; duplicate tags may coexist.

module dcache_writeback_buffer #(
  parameter int DEPTH        = 4,
  parameter int HIGH_WM      = 3,
  parameter int IDLE_TIMEOUT = 16,
  parameter int DATA_W       = 64,
  parameter int TAG_W        = 13,
  parameter int OFFSET_W     = 3,
  parameter int ZEROS_W      = 16,
  localparam int ADDR_W      = 1 + ZEROS_W + TAG_W + OFFSET_W,
  localparam int FWD_W       = 1 + DATA_W,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = PTR_W + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [1:0][ADDR_W-1:0] read_addrs,
  output logic [1:0][FWD_W-1:0]  fwd_outs,
  input  logic                   force_drain,
  output logic [ADDR_W-1:0]      wb_req_addr,
  output logic [DATA_W-1:0]      wb_req_data,
  input  logic                   wb_req_accepted,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int TMR_W = $clog2(IDLE_TIMEOUT) + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  occ;
  logic [DEPTH-1:0]  vld;
  logic [TMR_W-1:0]  timer;
  logic              overflow_q;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [TAG_W-1:0]  in_tag;
  logic              req;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic              co_ok;
  logic [PTR_W-1:0]  co_idx;
  logic [CNT_W-1:0]  occ_nxt;
  logic              unused_addr_bits;

  assign in_tag   = in_addr[OFFSET_W +: TAG_W];
  assign empty    = (occ == '0);
  assign full     = (occ == CNT_W'(DEPTH));
  assign count    = occ;
  assign overflow = overflow_q;

  assign req = (state == DRAIN) && !empty;
  assign pop = req && wb_req_accepted;

`ifdef DCACHE_WB_COALESCE_EN
  logic co_hit;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[head + PTR_W'(k)] && (tag_mem[head + PTR_W'(k)] == in_tag)) begin
        co_hit = 1'b1;
        co_idx = head + PTR_W'(k);
      end
    end
    // A head that leaves this cycle cannot absorb the write; allocate instead.
    co_ok = in_valid && co_hit && !(pop && (co_idx == head));
  end
`else
  assign co_ok  = 1'b0;
  assign co_idx = '0;
`endif

  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign push_ok = in_valid && !co_ok && (!full || pop);
  assign drop    = in_valid && !co_ok && full && !pop;
  assign occ_nxt = occ + CNT_W'(push_ok) - CNT_W'(pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      occ        <= '0;
      vld        <= '0;
      timer      <= '0;
      overflow_q <= 1'b0;
      state      <= IDLE;
    end else begin
      occ <= occ_nxt;
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      // Written after the pop clear: when full, head == tail and the push wins.
      if (push_ok) begin
        vld[tail] <= 1'b1;
        tail      <= tail + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if ((occ >= CNT_W'(HIGH_WM)) || force_drain ||
              ((timer == TMR_W'(IDLE_TIMEOUT - 1)) && !empty)) begin
            state <= DRAIN;
            timer <= '0;
          end else if (empty) begin
            timer <= '0;
          end else if (timer != TMR_W'(IDLE_TIMEOUT - 1)) begin
            timer <= timer + 1'b1;
          end
        end
        DRAIN: begin
          timer <= '0;
          if ((occ_nxt == '0) && !force_drain) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  // Payload storage carries no reset; liveness is tracked by vld.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      tag_mem[tail]  <= in_tag;
      data_mem[tail] <= in_data;
    end
    if (co_ok) begin
      data_mem[co_idx] <= in_data;
    end
  end

  // Request outputs are zero whenever no request is asserted.
  always_comb begin
    wb_req_addr = '0;
    wb_req_data = '0;
    if (req) begin
      wb_req_addr[ADDR_W-1]           = 1'b1;
      wb_req_addr[OFFSET_W +: TAG_W]  = tag_mem[head];
      wb_req_data                     = data_mem[head];
    end
  end

  // Forwarding: youngest buffered match, overridden by the incoming line.
  always_comb begin
    fwd_outs = '0;
    for (int j = 0; j < 2; j++) begin
      if (read_addrs[j][ADDR_W-1]) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (vld[head + PTR_W'(k)] &&
              (tag_mem[head + PTR_W'(k)] == read_addrs[j][OFFSET_W +: TAG_W])) begin
            fwd_outs[j] = {1'b1, data_mem[head + PTR_W'(k)]};
          end
        end
        if (in_valid && (in_tag == read_addrs[j][OFFSET_W +: TAG_W])) begin
          fwd_outs[j] = {1'b1, in_data};
        end
      end
    end
  end

  assign unused_addr_bits = ^{in_addr[ADDR_W-1:OFFSET_W+TAG_W], in_addr[OFFSET_W-1:0],
                              read_addrs[0][ADDR_W-2:OFFSET_W+TAG_W], read_addrs[0][OFFSET_W-1:0],
                              read_addrs[1][ADDR_W-2:OFFSET_W+TAG_W], read_addrs[1][OFFSET_W-1:0]};

endmodule

// File: tb/tb_dcache_writeback_buffer.sv
module tb_dcache_writeback_buffer;

  localparam int DEPTH        = 4;
  localparam int HIGH_WM      = 3;
  localparam int IDLE_TIMEOUT = 16;
  localparam int DATA_W       = 64;
  localparam int TAG_W        = 13;
  localparam int OFFSET_W     = 3;
  localparam int ZEROS_W      = 16;
  localparam int ADDR_W       = 1 + ZEROS_W + TAG_W + OFFSET_W;
  localparam int FWD_W        = 1 + DATA_W;
  localparam int CNT_W        = $clog2(DEPTH) + 1;

  logic                   clock;
  logic                   reset;
  logic                   in_valid;
  logic [ADDR_W-1:0]      in_addr;
  logic [DATA_W-1:0]      in_data;
  logic [1:0][ADDR_W-1:0] read_addrs;
  logic [1:0][FWD_W-1:0]  fwd_outs;
  logic                   force_drain;
  logic [ADDR_W-1:0]      wb_req_addr;
  logic [DATA_W-1:0]      wb_req_data;
  logic                   wb_req_accepted;
  logic [CNT_W-1:0]       count;
  logic                   full;
  logic                   empty;
  logic                   overflow;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_writeback_buffer dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .read_addrs      (read_addrs),
    .fwd_outs        (fwd_outs),
    .force_drain     (force_drain),
    .wb_req_addr     (wb_req_addr),
    .wb_req_data     (wb_req_data),
    .wb_req_accepted (wb_req_accepted),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .overflow        (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model state
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t q[$];
  bit   m_drain;
  int   m_timer;
  bit   m_ovf;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic v, input logic [TAG_W-1:0] t,
                                                input logic [OFFSET_W-1:0] off);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[ADDR_W-1] = v;
    a[OFFSET_W +: TAG_W] = t;
    a[OFFSET_W-1:0] = off;
    return a;
  endfunction

  function automatic logic [FWD_W-1:0] model_fwd(input logic [ADDR_W-1:0] ra);
    logic [TAG_W-1:0] t;
    logic [FWD_W-1:0] r;
    t = ra[OFFSET_W +: TAG_W];
    r = '0;
    if (ra[ADDR_W-1]) begin
      if (in_valid && in_addr[OFFSET_W +: TAG_W] == t) begin
        r = {1'b1, in_data};
      end else begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (r[FWD_W-1] == 1'b0 && q[i].tag == t) r = {1'b1, q[i].data};
        end
      end
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid        = 1'b0;
    in_addr         = '0;
    in_data         = '0;
    read_addrs      = '0;
    force_drain     = 1'b0;
    wb_req_accepted = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic push_line(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_addr  = mk_addr(1'b1, t, 3'(t));
    in_data  = d;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    read_addrs[0] = mk_addr(1'b1, 13'h0, 3'h0);
    @(negedge clock);
    n_checks++;
    if (wb_req_addr !== '0 || wb_req_data !== '0 || fwd_outs !== '0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%h data=%h fwd=%h full=%b required all zero",
               wb_req_addr, wb_req_data, fwd_outs, full);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      n_checks++;
      if (empty !== 1'b1 || count !== '0 || wb_req_addr[ADDR_W-1] !== 1'b0 || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: empty=%b count=%0d req=%b ovf=%b required 1/0/0/0",
                 c, empty, count, wb_req_addr[ADDR_W-1], overflow);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_drain_order;
    logic [TAG_W-1:0] t;
    do_reset();
    wb_req_accepted = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = 13'h10 + 13'(i);
      push_line(t, {32'hD0D0_0000, 32'(i)});
      tick();
    end
    in_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (count !== 3'd3 || wb_req_addr[ADDR_W-1] !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_pre_req: count=%0d req=%b required 3/0", count, wb_req_addr[ADDR_W-1]);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      t = 13'h10 + 13'(i);
      @(negedge clock);
      n_checks++;
      if (wb_req_addr !== mk_addr(1'b1, t, 3'h0) || wb_req_data !== {32'hD0D0_0000, 32'(i)}) begin
        n_fail++;
        $display("FAIL drain_order %0d: addr=%h data=%h required %h %h", i, wb_req_addr,
                 wb_req_data, mk_addr(1'b1, t, 3'h0), {32'hD0D0_0000, 32'(i)});
      end
      tick();
    end
    @(negedge clock);
    n_checks++;
    if (empty !== 1'b1 || wb_req_addr[ADDR_W-1] !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_done: empty=%b req=%b required 1/0", empty, wb_req_addr[ADDR_W-1]);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout;
    logic exp_req;
    do_reset();
    wb_req_accepted = 1'b1;
    push_line(13'h20, 64'h2020_2020_ABCD_0001);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= IDLE_TIMEOUT + 1; c++) begin
      exp_req = (c == IDLE_TIMEOUT + 1);
      @(negedge clock);
      n_checks++;
      if (wb_req_addr[ADDR_W-1] !== exp_req ||
          (exp_req && wb_req_addr[OFFSET_W +: TAG_W] !== 13'h20)) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: req=%b tag=%h required %b tag 20", c,
                 wb_req_addr[ADDR_W-1], wb_req_addr[OFFSET_W +: TAG_W], exp_req);
      end
      tick();
    end
    @(negedge clock);
    n_checks++;
    if (empty !== 1'b1 || count !== '0) begin
      n_fail++;
      $display("FAIL timeout_empty: empty=%b count=%0d required 1/0", empty, count);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_drain;
    bit seen;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_line(13'h70 + 13'(i), 64'(i));
      tick();
    end
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clock);
      seen = wb_req_addr[ADDR_W-1];
      tick();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mid_drain_req: no request within bound, required request");
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < IDLE_TIMEOUT + 4; c++) begin
      @(negedge clock);
      n_checks++;
      if (wb_req_addr[ADDR_W-1] !== 1'b0 || empty !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_drain_reset cycle %0d: req=%b empty=%b required 0/1", c,
                 wb_req_addr[ADDR_W-1], empty);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push_line(13'h31 + 13'(i), 64'h3100 + 64'(i));
      tick();
    end
    push_line(13'h30, 64'hDEAD);
    @(negedge clock);
    n_checks++;
    if (full !== 1'b1 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_full: full=%b count=%0d required 1/4", full, count);
    end
    tick();
    push_line(13'h35, 64'h3500);
    wb_req_accepted = 1'b1;
    read_addrs[0] = mk_addr(1'b1, 13'h30, 3'h0);
    @(negedge clock);
    n_checks++;
    if (overflow !== 1'b1 || count !== 3'd4 || fwd_outs[0] !== '0) begin
      n_fail++;
      $display("FAIL ovf_drop: ovf=%b count=%0d fwd0=%h required 1/4/0", overflow, count, fwd_outs[0]);
    end
    n_checks++;
    if (wb_req_addr[OFFSET_W +: TAG_W] !== 13'h31 || wb_req_addr[ADDR_W-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_head: addr=%h required head tag 31 valid", wb_req_addr);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (count !== 3'd4 || overflow !== 1'b1 || wb_req_addr[OFFSET_W +: TAG_W] !== 13'h32) begin
      n_fail++;
      $display("FAIL ovf_pushpop: count=%0d ovf=%b head=%h required 4/1/32", count, overflow,
               wb_req_addr[OFFSET_W +: TAG_W]);
    end
    for (int c = 0; c < 10 && !empty; c++) tick();
    @(negedge clock);
    n_checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: empty=%b ovf=%b required 1/1", empty, overflow);
    end
    do_reset();
    @(negedge clock);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_reset: ovf=%b required 0", overflow);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_forwarding;
    logic [DATA_W-1:0] da, db;
    da = 64'hAAAA_0000_1111_0040;
    db = 64'hBBBB_0000_2222_0041;
    do_reset();
    push_line(13'h40, da);
    tick();
    push_line(13'h41, db);
    read_addrs[0] = mk_addr(1'b1, 13'h41, 3'h0);
    read_addrs[1] = mk_addr(1'b1, 13'h40, 3'h5);
    @(negedge clock);
    n_checks++;
    if (fwd_outs[0] !== {1'b1, db} || fwd_outs[1] !== {1'b1, da}) begin
      n_fail++;
      $display("FAIL fwd_same_cycle: fwd0=%h fwd1=%h required %h %h", fwd_outs[0], fwd_outs[1],
               {1'b1, db}, {1'b1, da});
    end
    tick();
    in_valid = 1'b0;
    read_addrs[0] = mk_addr(1'b1, 13'h42, 3'h0);
    read_addrs[1] = mk_addr(1'b1, 13'h41, 3'h2);
    @(negedge clock);
    n_checks++;
    if (fwd_outs[0] !== '0 || fwd_outs[1] !== {1'b1, db}) begin
      n_fail++;
      $display("FAIL fwd_miss: fwd0=%h fwd1=%h required 0 %h", fwd_outs[0], fwd_outs[1], {1'b1, db});
    end
    tick();
    read_addrs[0] = mk_addr(1'b0, 13'h40, 3'h0);
    read_addrs[1] = mk_addr(1'b1, 13'h40, 3'h7);
    @(negedge clock);
    n_checks++;
    if (fwd_outs[0] !== '0 || fwd_outs[1] !== {1'b1, da}) begin
      n_fail++;
      $display("FAIL fwd_invalid_read: fwd0=%h fwd1=%h required 0 %h", fwd_outs[0], fwd_outs[1],
               {1'b1, da});
    end
    tick();
    read_addrs = '0;
    force_drain = 1'b1;
    wb_req_accepted = 1'b1;
    for (int c = 0; c < 10 && !empty; c++) tick();
    force_drain = 1'b0;
    tick();
    @(negedge clock);
    n_checks++;
    if (empty !== 1'b1 || wb_req_addr[ADDR_W-1] !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_drain: empty=%b req=%b required 1/0", empty, wb_req_addr[ADDR_W-1]);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_duplicate;
    logic [DATA_W-1:0] da, dc;
    logic [DATA_W-1:0] got[$];
    logic [CNT_W-1:0]  exp_cnt;
    da = 64'h5050_AAAA_0000_0001;
    dc = 64'h5050_CCCC_0000_0003;
`ifdef DCACHE_WB_COALESCE_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd2;
`endif
    do_reset();
    push_line(13'h50, da);
    tick();
    push_line(13'h50, dc);
    tick();
    in_valid = 1'b0;
    read_addrs[0] = mk_addr(1'b1, 13'h50, 3'h0);
    @(negedge clock);
    n_checks++;
    if (count !== exp_cnt || fwd_outs[0] !== {1'b1, dc}) begin
      n_fail++;
      $display("FAIL dup_count: count=%0d fwd0=%h required %0d %h", count, fwd_outs[0], exp_cnt,
               {1'b1, dc});
    end
    force_drain = 1'b1;
    wb_req_accepted = 1'b1;
    read_addrs = '0;
    tick();
    force_drain = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (wb_req_addr[ADDR_W-1] === 1'b1) got.push_back(wb_req_data);
      tick();
    end
    n_checks++;
`ifdef DCACHE_WB_COALESCE_EN
    if (got.size() != 1 || got[0] !== dc) begin
      n_fail++;
      $display("FAIL dup_drain: drained %0d lines first=%h required 1 line %h", got.size(),
               (got.size() > 0) ? got[0] : '0, dc);
    end
`else
    if (got.size() != 2 || got[0] !== da || got[1] !== dc) begin
      n_fail++;
      $display("FAIL dup_drain: drained %0d lines first=%h required 2 lines %h then %h", got.size(),
               (got.size() > 0) ? got[0] : '0, da, dc);
    end
`endif
    idle_inputs();
  endtask

  task automatic test_random;
    bit                m_req, pop, coalesced, found;
    int                size0;
    logic [TAG_W-1:0]  t;
    logic [CNT_W-1:0]  exp_cnt;
    logic [FWD_W-1:0]  exp_fwd;
    ent_t              e;
    do_reset();
    q.delete();
    m_drain = 0;
    m_timer = 0;
    m_ovf   = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid        = ($urandom_range(0, 1) == 1);
      in_addr         = mk_addr(1'($urandom_range(0, 1)), 13'h60 + 13'($urandom_range(0, 5)),
                                3'($urandom_range(0, 7)));
      in_data         = {$urandom, $urandom};
      for (int j = 0; j < 2; j++)
        read_addrs[j] = mk_addr(1'($urandom_range(0, 1)), 13'h60 + 13'($urandom_range(0, 5)),
                                3'($urandom_range(0, 7)));
      wb_req_accepted = ($urandom_range(0, 2) != 0);
      force_drain     = ($urandom_range(0, 19) == 0);
      @(negedge clock);

      m_req   = m_drain && (q.size() > 0);
      exp_cnt = CNT_W'(q.size());
      n_checks++;
      if (count !== exp_cnt || overflow !== m_ovf || wb_req_addr[ADDR_W-1] !== m_req) begin
        n_fail++;
        $display("FAIL rand_state cyc %0d: count=%0d ovf=%b req=%b required %0d/%b/%b", cyc,
                 count, overflow, wb_req_addr[ADDR_W-1], exp_cnt, m_ovf, m_req);
      end
      if (m_req) begin
        n_checks++;
        if (wb_req_addr !== mk_addr(1'b1, q[0].tag, 3'h0) || wb_req_data !== q[0].data) begin
          n_fail++;
          $display("FAIL rand_head cyc %0d: addr=%h data=%h required %h %h", cyc, wb_req_addr,
                   wb_req_data, mk_addr(1'b1, q[0].tag, 3'h0), q[0].data);
        end
      end
      for (int j = 0; j < 2; j++) begin
        exp_fwd = model_fwd(read_addrs[j]);
        n_checks++;
        if (fwd_outs[j] !== exp_fwd) begin
          n_fail++;
          $display("FAIL rand_fwd%0d cyc %0d: got %h required %h", j, cyc, fwd_outs[j], exp_fwd);
        end
      end

      // Model update for the coming edge.
      size0     = q.size();
      pop       = m_req && wb_req_accepted;
      t         = in_addr[OFFSET_W +: TAG_W];
      coalesced = 0;
`ifdef DCACHE_WB_COALESCE_EN
      found = 0;
      if (in_valid) begin
        for (int i = size0 - 1; i >= 0; i--) begin
          if (!found && q[i].tag == t) begin
            found = 1;
            if (!(pop && i == 0)) begin
              q[i].data = in_data;
              coalesced = 1;
            end
          end
        end
      end
`else
      found = 0;
`endif
      if (pop) void'(q.pop_front());
      if (in_valid && !coalesced) begin
        if (size0 < DEPTH || pop) begin
          e.tag  = t;
          e.data = in_data;
          q.push_back(e);
        end else begin
          m_ovf = 1;
        end
      end
      if (!m_drain) begin
        if (size0 >= HIGH_WM || force_drain || (m_timer == IDLE_TIMEOUT - 1 && size0 > 0)) begin
          m_drain = 1;
          m_timer = 0;
        end else if (size0 == 0) begin
          m_timer = 0;
        end else if (m_timer < IDLE_TIMEOUT - 1) begin
          m_timer++;
        end
      end else begin
        m_timer = 0;
        if (q.size() == 0 && !force_drain) m_drain = 0;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_drain_order();
    test_timeout();
    test_reset_mid_drain();
    test_overflow();
    test_forwarding();
    test_duplicate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
